// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima core: control decode and branch predictor state.
package rv32ima_pkg;

    // Default number of predictor/target entries.
    localparam int unsigned BHT_DEPTH_DEFAULT = 64;

    // Branch condition, encoded as the RV32 funct3 field.
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_type_t;

    typedef struct packed {
        logic         is_branch;
        logic         is_jump;
        branch_type_t branch_type;
    } control_type_t;

    // 2-bit saturating predictor states.
    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } bht_state_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state function with increment, decrement and load.
module sat_counter2
    import rv32ima_pkg::*;
(
    input  bht_state_t cur,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  bht_state_t load_val,
    output bht_state_t nxt
);

    // Load wins over stepping; stepping saturates at SN/ST.
    always_comb begin
        nxt = cur;
        if (load) begin
            nxt = load_val;
        end else if (inc) begin
            unique case (cur)
                SN: nxt = WN;
                WN: nxt = WT;
                WT: nxt = ST;
                ST: nxt = ST;
                default: nxt = cur;
            endcase
        end else if (dec) begin
            unique case (cur)
                SN: nxt = SN;
                WN: nxt = SN;
                WT: nxt = WN;
                ST: nxt = WT;
                default: nxt = cur;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal branch predictor with tagged target buffer and
// resolve-stage mispredict detection / redirect.
module branch_predictor
    import rv32ima_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = BHT_DEPTH_DEFAULT,
    parameter int unsigned PC_W      = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [PC_W-1:0]     fetch_pc,
    output logic                pred_taken,
    output logic [PC_W-1:0]     pred_target,
    input  logic                res_valid,
    input  logic [PC_W-1:0]     res_pc,
    input  control_type_t       res_control_type,
    input  logic                res_zero,
    input  logic                res_neg,
    input  logic [PC_W-1:0]     res_branch_addr,
    input  logic [PC_W-1:0]     res_jump_addr,
    input  logic                res_pred_taken,
    input  logic [PC_W-1:0]     res_pred_target,
    output logic                next_addr_en,
    output logic [PC_W-1:0]     next_addr,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic              valid_q [BHT_DEPTH];
    bht_state_t        cnt_q   [BHT_DEPTH];
    logic [TAG_W-1:0]  tag_q   [BHT_DEPTH];
    logic [PC_W-1:0]   tgt_q   [BHT_DEPTH];

    logic [IDX_W-1:0]  fetch_idx, res_idx;
    logic [TAG_W-1:0]  fetch_tag, res_tag;
    logic              fetch_hit, res_hit;
    logic              is_br, is_jmp, active;
    logic              br_taken, act_taken, mispredict;
    logic [PC_W-1:0]   act_target;
    bht_state_t        cnt_nxt;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[PC_W-1:IDX_W+2];
    assign res_idx   = res_pc[IDX_W+1:2];
    assign res_tag   = res_pc[PC_W-1:IDX_W+2];

    // Fetch-side lookup; reads pre-edge table contents, no bypass from resolve.
    always_comb begin
        fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        pred_taken  = fetch_hit && (cnt_q[fetch_idx] == WT || cnt_q[fetch_idx] == ST);
        pred_target = pred_taken ? tgt_q[fetch_idx] : '0;
    end

    // Resolve-side outcome, target and mispredict detection.
    always_comb begin
        is_br    = res_valid && res_control_type.is_branch;
        is_jmp   = res_valid && !res_control_type.is_branch && res_control_type.is_jump;
        active   = is_br || is_jmp;
        res_hit  = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
        br_taken = 1'b0;
        case (res_control_type.branch_type)
            BEQ:     br_taken = res_zero && !res_neg;
            BNE:     br_taken = !res_zero;
            BLT:     br_taken = !res_zero;
            BGE:     br_taken = res_zero;
            BLTU:    br_taken = !res_zero;
            BGEU:    br_taken = res_zero;
            default: br_taken = 1'b0;
        endcase
        act_taken  = is_br ? br_taken : 1'b1;
        act_target = is_br ? res_branch_addr : res_jump_addr;
        mispredict = active && ((act_taken != res_pred_taken) ||
                     (act_taken && res_pred_taken && (act_target != res_pred_target)));
        next_addr_en = mispredict;
        next_addr    = '0;
        if (mispredict) begin
            next_addr = act_taken ? act_target : res_pc + PC_W'(4);
        end
    end

    // Jumps and branch allocations load a fixed state; branch hits step.
    sat_counter2 u_cnt (
        .cur      (cnt_q[res_idx]),
        .inc      (act_taken),
        .dec      (!act_taken),
        .load     (is_jmp || !res_hit),
        .load_val (is_jmp ? ST : WT),
        .nxt      (cnt_nxt)
    );

    // Table update from the resolving instruction; reset clears everything.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= WN;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
        end else if (is_br) begin
            if (res_hit) begin
                cnt_q[res_idx] <= cnt_nxt;
                if (act_taken) tgt_q[res_idx] <= act_target;
            end else if (act_taken) begin
                valid_q[res_idx] <= 1'b1;
                cnt_q[res_idx]   <= cnt_nxt;
                tag_q[res_idx]   <= res_tag;
                tgt_q[res_idx]   <= act_target;
            end
        end else if (is_jmp) begin
            valid_q[res_idx] <= 1'b1;
            cnt_q[res_idx]   <= cnt_nxt;
            tag_q[res_idx]   <= res_tag;
            tgt_q[res_idx]   <= act_target;
        end
    end

    // Saturating event counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (active && stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispredicts != 32'hFFFF_FFFF) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// resolve/fetch traffic against an array-based reference model.
module tb_branch_predictor;
    import rv32ima_pkg::*;

    localparam int DEPTH = 64;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [31:0]   fetch_pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          res_valid;
    logic [31:0]   res_pc;
    control_type_t res_control_type;
    logic          res_zero, res_neg;
    logic [31:0]   res_branch_addr, res_jump_addr;
    logic          res_pred_taken;
    logic [31:0]   res_pred_target;
    logic          next_addr_en;
    logic [31:0]   next_addr;
    logic [31:0]   stat_branches, stat_mispredicts;

    branch_predictor #(.BHT_DEPTH(DEPTH), .PC_W(32)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_control_type (res_control_type),
        .res_zero         (res_zero),
        .res_neg          (res_neg),
        .res_branch_addr  (res_branch_addr),
        .res_jump_addr    (res_jump_addr),
        .res_pred_taken   (res_pred_taken),
        .res_pred_target  (res_pred_target),
        .next_addr_en     (next_addr_en),
        .next_addr        (next_addr),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-index owner tag, counter value 0..3, target.
    bit          m_valid [DEPTH];
    int          m_cnt   [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    longint      m_br, m_mis;

    logic        obs_pt, obs_en;
    logic [31:0] obs_ptgt, obs_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_cnt[i] = 1; m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_br = 0; m_mis = 0;
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 8));
    endfunction

    task automatic m_pred(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        t   = m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
        tgt = t ? m_tgt[m_idx(pc)] : 32'h0;
    endtask

    function automatic bit m_br_taken(input logic [2:0] bt, input logic z, input logic n);
        case (bt)
            3'd0: return z && !n;
            3'd1: return !z;
            3'd4: return !z;
            3'd5: return z;
            3'd6: return !z;
            3'd7: return z;
            default: return 0;
        endcase
    endfunction

    // One cycle: drive at negedge, check combinational outputs, then check
    // stats after the edge and advance the model.
    task automatic step(input logic [31:0] fpc, input logic rv, input logic [31:0] rpc,
                        input logic br, input logic jmp, input logic [2:0] bt,
                        input logic z, input logic n, input logic [31:0] baddr,
                        input logic [31:0] jaddr, input logic pt, input logic [31:0] ptgt);
        logic        e_pt, tk, mis, act;
        logic [31:0] e_ptgt, tgt, e_addr;
        int          i;
        @(negedge CLK);
        fetch_pc = fpc; res_valid = rv; res_pc = rpc;
        res_control_type.is_branch   = br;
        res_control_type.is_jump     = jmp;
        res_control_type.branch_type = branch_type_t'(bt);
        res_zero = z; res_neg = n; res_branch_addr = baddr; res_jump_addr = jaddr;
        res_pred_taken = pt; res_pred_target = ptgt;
        #1;
        m_pred(fpc, e_pt, e_ptgt);
        act    = rv && (br || jmp);
        tk     = br ? m_br_taken(bt, z, n) : 1'b1;
        tgt    = br ? baddr : jaddr;
        mis    = act && ((tk != pt) || (tk && pt && tgt != ptgt));
        e_addr = !mis ? 32'h0 : (tk ? tgt : rpc + 32'd4);
        obs_pt = pred_taken; obs_ptgt = pred_target;
        obs_en = next_addr_en; obs_addr = next_addr;
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, e_pt});
        chk("pred_target", pred_target, e_ptgt);
        chk("next_addr_en", {31'b0, next_addr_en}, {31'b0, mis});
        chk("next_addr", next_addr, e_addr);
        @(posedge CLK);
        #1;
        i = m_idx(rpc);
        if (rv && br) begin
            if (m_hit(rpc)) begin
                m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                              : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
                if (tk) m_tgt[i] = tgt;
            end else if (tk) begin
                m_valid[i] = 1; m_cnt[i] = 2; m_tag[i] = rpc >> 8; m_tgt[i] = tgt;
            end
        end else if (rv && jmp) begin
            m_valid[i] = 1; m_cnt[i] = 3; m_tag[i] = rpc >> 8; m_tgt[i] = jaddr;
        end
        if (act) m_br++;
        if (mis) m_mis++;
        chk("stat_branches", stat_branches, 32'(m_br));
        chk("stat_mispredicts", stat_mispredicts, 32'(m_mis));
    endtask

    task automatic fetch_only(input logic [31:0] fpc);
        step(fpc, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] rpc, fpc, ba, ja, ptg;
        logic        br, jmp, pt;
        nRST = 1'b0; fetch_pc = 32'h100; res_valid = 1'b0; res_pc = '0;
        res_control_type = '0; res_zero = 1'b0; res_neg = 1'b0;
        res_branch_addr = '0; res_jump_addr = '0; res_pred_taken = 1'b0; res_pred_target = '0;
        m_reset();
        #12;
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("rst_pred_target", pred_target, 32'h0);
        chk("rst_stat_br", stat_branches, 32'h0);
        chk("rst_stat_mis", stat_mispredicts, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // BEQ at 0x100 taken, predicted not taken: redirect to 0x180.
        step(32'h100, 1, 32'h100, 1, 0, 3'd0, 1, 0, 32'h180, 32'h0, 0, 32'h0);
        chk("beq_redirect_en", {31'b0, obs_en}, 32'h1);
        chk("beq_redirect_addr", obs_addr, 32'h180);
        fetch_only(32'h100);
        chk("beq_alloc_pt", {31'b0, obs_pt}, 32'h1);
        chk("beq_alloc_tgt", obs_ptgt, 32'h180);
        // Two more taken, then not taken: falls through to 0x104, still predicts taken.
        step(32'h0, 1, 32'h100, 1, 0, 3'd0, 1, 0, 32'h180, 32'h0, 1, 32'h180);
        step(32'h0, 1, 32'h100, 1, 0, 3'd0, 1, 0, 32'h180, 32'h0, 1, 32'h180);
        step(32'h0, 1, 32'h100, 1, 0, 3'd0, 0, 0, 32'h180, 32'h0, 1, 32'h180);
        chk("beq_nt_addr", obs_addr, 32'h104);
        fetch_only(32'h100);
        chk("beq_st_to_wt_pt", {31'b0, obs_pt}, 32'h1);
        // JAL at 0x200 (aliases 0x100) with a stale target.
        step(32'h0, 1, 32'h200, 0, 1, 3'd0, 0, 0, 32'h0, 32'h400, 1, 32'h300);
        chk("jal_redirect", obs_addr, 32'h400);
        fetch_only(32'h200);
        chk("jal_tgt", obs_ptgt, 32'h400);
        fetch_only(32'h100);
        chk("alias_no_hit", {31'b0, obs_pt}, 32'h0);
        // BLTU zero=1 not taken, predicted not taken: no redirect, no allocation.
        step(32'h0, 1, 32'h300, 1, 0, 3'd6, 1, 0, 32'h500, 32'h0, 0, 32'h0);
        chk("bltu_no_redirect", {31'b0, obs_en}, 32'h0);
        fetch_only(32'h300);
        chk("bltu_no_alloc", {31'b0, obs_pt}, 32'h0);
        chk("dir_stat_br", stat_branches, 32'd6);
        chk("dir_stat_mis", stat_mispredicts, 32'd3);

        // Random traffic over a small PC pool to exercise hits, aliasing and churn.
        for (int k = 0; k < 400; k++) begin
            logic tmp_t;
            rpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
            fpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
            ba  = 32'h1000 | ($urandom_range(0, 7) << 4);
            ja  = 32'h2000 | ($urandom_range(0, 7) << 4);
            br  = 1'($urandom);
            jmp = 1'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                m_pred(rpc, tmp_t, ptg);
                pt = tmp_t;
            end else begin
                pt  = 1'($urandom);
                ptg = 32'h1000 | ($urandom_range(0, 7) << 4);
            end
            step(fpc, ($urandom_range(0, 5) != 0), rpc, br, jmp, 3'($urandom),
                 1'($urandom), 1'($urandom), ba, ja, pt, ptg);
        end

        // Reset during an active update: table and stats cleared immediately.
        @(negedge CLK);
        fetch_pc = 32'h200; res_valid = 1'b1; res_pc = 32'h200;
        res_control_type.is_branch = 1'b0; res_control_type.is_jump = 1'b1;
        res_jump_addr = 32'h400;
        nRST = 1'b0;
        #1;
        chk("mid_rst_pt", {31'b0, pred_taken}, 32'h0);
        chk("mid_rst_tgt", pred_target, 32'h0);
        chk("mid_rst_stat_br", stat_branches, 32'h0);
        chk("mid_rst_stat_mis", stat_mispredicts, 32'h0);
        @(posedge CLK);
        #1;
        chk("mid_rst_hold_pt", {31'b0, pred_taken}, 32'h0);
        m_reset();
        @(negedge CLK);
        res_valid = 1'b0;
        nRST = 1'b1;
        fetch_only(32'h200);
        chk("post_rst_no_hit", {31'b0, obs_pt}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
